// File: rtl/edge_adder_switch_acc.sv
// Edge adder switch with a per-node temporal fold accumulator for VNs wider than the tree.
// Build option: define EDGE_ADD_SAT_EN for signed saturating sums; undefined wraps modulo 2^DATA_TYPE.
module edge_adder_switch_acc #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_IN    = 2,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  logic [DATA_TYPE*NUM_IN-1:0] i_data_bus,
  input  logic [SEL_IN-1:0]           i_sel,
  input  logic [2:0]                  i_cmd,
  input  logic [CNT_W-1:0]            i_fold,
  output logic [DATA_TYPE-1:0]        o_adder,
  output logic                        o_adder_valid,
  output logic [2*DATA_TYPE-1:0]      o_vn,
  output logic [1:0]                  o_vn_valid,
  output logic                        o_busy,
  output logic [CNT_W-1:0]            o_fold_cnt
);

  localparam int DT   = DATA_TYPE;
  localparam int HALF = NUM_IN / 2;

  localparam logic [2:0] CMD_ADD   = 3'b010;
  localparam logic [2:0] CMD_RIGHT = 3'b011;
  localparam logic [2:0] CMD_LEFT  = 3'b100;
  localparam logic [2:0] CMD_SPLIT = 3'b101;
  localparam logic [2:0] CMD_FOLD  = 3'b110;
  localparam logic [2:0] CMD_FLUSH = 3'b111;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  // Handshake: no backpressure. A beat is taken on every clock where i_valid=1,
  // and each result appears exactly one cycle later as a single-cycle valid pulse.

  state_t           r_state;
  logic [DT-1:0]    r_acc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_target;
  logic [DT-1:0]    r_adder;
  logic             r_adder_valid;
  logic [2*DT-1:0]  r_vn;
  logic [1:0]       r_vn_valid;

  logic [DT-1:0]    w_lane [NUM_IN];
  logic [DT-1:0]    w_left;
  logic [DT-1:0]    w_right;
  logic [DT-1:0]    w_sum;
  logic [DT-1:0]    w_acc_sum;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_target;
  logic             w_fold_done;

  function automatic logic [DT-1:0] add_fn(input logic [DT-1:0] a, input logic [DT-1:0] b);
    logic [DT-1:0] s;
    s = a + b;
`ifdef EDGE_ADD_SAT_EN
    if ((a[DT-1] == b[DT-1]) && (s[DT-1] != a[DT-1])) begin
      s = a[DT-1] ? {1'b1, {(DT-1){1'b0}}} : {1'b0, {(DT-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      w_lane[k] = i_data_bus[k*DT +: DT];
    end
  end

  // i_sel indexes the same position in both halves; out-of-range selects fall back to index 0.
  always_comb begin
    w_left  = w_lane[HALF];
    w_right = w_lane[0];
    for (int k = 0; k < HALF; k++) begin
      if (i_sel == SEL_IN'(k)) begin
        w_left  = w_lane[HALF + k];
        w_right = w_lane[k];
      end
    end
  end

  always_comb begin
    w_sum       = add_fn(w_left, w_right);
    w_acc_sum   = add_fn(r_acc, w_sum);
    w_cnt_inc   = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);
    w_target    = r_target;
    if (r_state == IDLE) begin
      w_target = (i_fold == '0) ? CNT_W'(1) : i_fold;
    end
    w_fold_done = (w_cnt_inc >= w_target);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_count       <= '0;
      r_target      <= '0;
      r_adder       <= '0;
      r_adder_valid <= 1'b0;
      r_vn          <= '0;
      r_vn_valid    <= 2'b00;
    end else begin
      r_adder_valid <= 1'b0;
      r_vn_valid    <= 2'b00;
      if (i_valid) begin
        case (i_cmd)
          CMD_ADD: begin
            r_adder       <= w_sum;
            r_adder_valid <= 1'b1;
          end
          CMD_RIGHT: begin
            r_vn[DT-1:0]  <= w_lane[0];
            r_vn_valid    <= 2'b01;
            r_adder       <= w_right;
            r_adder_valid <= 1'b1;
          end
          CMD_LEFT: begin
            r_vn[2*DT-1:DT] <= w_lane[NUM_IN-1];
            r_vn_valid      <= 2'b10;
            r_adder         <= w_left;
            r_adder_valid   <= 1'b1;
          end
          CMD_SPLIT: begin
            r_vn       <= {w_left, w_right};
            r_vn_valid <= 2'b11;
          end
          CMD_FOLD: begin
            if (w_fold_done) begin
              r_vn[DT-1:0] <= w_acc_sum;
              r_vn_valid   <= 2'b01;
              r_acc        <= '0;
              r_count      <= '0;
              r_state      <= IDLE;
            end else begin
              r_acc   <= w_acc_sum;
              r_count <= w_cnt_inc;
              r_state <= ACC;
              if (r_state == IDLE) begin
                r_target <= w_target;
              end
            end
          end
          CMD_FLUSH: begin
            r_vn[DT-1:0] <= w_acc_sum;
            r_vn_valid   <= 2'b01;
            r_acc        <= '0;
            r_count      <= '0;
            r_state      <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_adder       = r_adder;
  assign o_adder_valid = r_adder_valid;
  assign o_vn          = r_vn;
  assign o_vn_valid    = r_vn_valid;
  assign o_busy        = (r_state == ACC);
  assign o_fold_cnt    = r_count;

endmodule

// File: tb/tb_edge_adder_switch_acc.sv
// Directed table-driven bench for edge_adder_switch_acc (default parameters: 32-bit, 4 lanes).
module tb_edge_adder_switch_acc;

  localparam int DT  = 32;
  localparam int NIN = 4;
  localparam int SW  = 2;
  localparam int CW  = 8;

`ifdef EDGE_ADD_SAT_EN
  localparam logic [DT-1:0] OVF_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [DT-1:0] OVF_EXP = 32'h8000_0000;
`endif

  logic              clk;
  logic              rst;
  logic              i_valid;
  logic [DT*NIN-1:0] i_data_bus;
  logic [SW-1:0]     i_sel;
  logic [2:0]        i_cmd;
  logic [CW-1:0]     i_fold;
  logic [DT-1:0]     o_adder;
  logic              o_adder_valid;
  logic [2*DT-1:0]   o_vn;
  logic [1:0]        o_vn_valid;
  logic              o_busy;
  logic [CW-1:0]     o_fold_cnt;

  edge_adder_switch_acc #(
    .DATA_TYPE(DT), .NUM_IN(NIN), .SEL_IN(SW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .i_sel(i_sel), .i_cmd(i_cmd), .i_fold(i_fold),
    .o_adder(o_adder), .o_adder_valid(o_adder_valid), .o_vn(o_vn),
    .o_vn_valid(o_vn_valid), .o_busy(o_busy), .o_fold_cnt(o_fold_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [2:0]        cmd;
    logic [SW-1:0]     sel;
    logic [CW-1:0]     fold;
    logic [DT*NIN-1:0] bus;
    logic [DT-1:0]     e_adder;
    logic              e_av;
    logic [2*DT-1:0]   e_vn;
    logic [1:0]        e_vv;
    logic              e_busy;
    logic [CW-1:0]     e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [DT*NIN-1:0] bus4(input logic [DT-1:0] l3, input logic [DT-1:0] l2,
                                             input logic [DT-1:0] l1, input logic [DT-1:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic add_vec(input logic v, input logic [2:0] cmd, input logic [SW-1:0] sel,
                         input logic [CW-1:0] fold, input logic [DT*NIN-1:0] bus,
                         input logic [DT-1:0] ea, input logic eav, input logic [2*DT-1:0] evn,
                         input logic [1:0] evv, input logic eb, input logic [CW-1:0] ec);
    vec_t t;
    t.valid = v; t.cmd = cmd; t.sel = sel; t.fold = fold; t.bus = bus;
    t.e_adder = ea; t.e_av = eav; t.e_vn = evn; t.e_vv = evv; t.e_busy = eb; t.e_cnt = ec;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [DT-1:0] ea, input logic eav,
                         input logic [2*DT-1:0] evn, input logic [1:0] evv,
                         input logic eb, input logic [CW-1:0] ec);
    chk("o_adder", idx, 64'(o_adder), 64'(ea));
    chk("o_adder_valid", idx, 64'(o_adder_valid), 64'(eav));
    chk("o_vn", idx, 64'(o_vn), 64'(evn));
    chk("o_vn_valid", idx, 64'(o_vn_valid), 64'(evv));
    chk("o_busy", idx, 64'(o_busy), 64'(eb));
    chk("o_fold_cnt", idx, 64'(o_fold_cnt), 64'(ec));
  endtask

  // driver
  task automatic drive(input logic v, input logic [2:0] cmd, input logic [SW-1:0] sel,
                       input logic [CW-1:0] fold, input logic [DT*NIN-1:0] bus);
    i_valid = v; i_cmd = cmd; i_sel = sel; i_fold = fold; i_data_bus = bus;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'b000, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk_all(-1, '0, 1'b0, '0, 2'b00, 1'b0, '0);
    rst = 1'b0;

    // sel=1 picks L=lane3, R=lane1; sel=0 picks L=lane2, R=lane0
    for (int i = 0; i < 5; i++)
      add_vec(0, 3'b000, 1, 0, '0, 0, 0, 0, 2'b00, 0, 0);
    add_vec(1, 3'b010, 1, 0, bus4(5, 0, 7, 0), 12, 1, 0, 2'b00, 0, 0);
    add_vec(0, 3'b010, 1, 0, bus4(5, 0, 7, 0), 12, 0, 0, 2'b00, 0, 0);
    add_vec(1, 3'b101, 1, 0, bus4(32'h11, 0, 32'h22, 0), 12, 0, {32'h11, 32'h22}, 2'b11, 0, 0);
    add_vec(1, 3'b011, 1, 0, bus4(0, 0, 4, 9), 4, 1, {32'h11, 32'd9}, 2'b01, 0, 0);
    add_vec(1, 3'b100, 1, 0, bus4(32'h33, 0, 1, 2), 32'h33, 1, {32'h33, 32'd9}, 2'b10, 0, 0);
    add_vec(1, 3'b000, 1, 0, bus4(7, 7, 7, 7), 32'h33, 0, {32'h33, 32'd9}, 2'b00, 0, 0);
    add_vec(1, 3'b001, 1, 0, bus4(7, 7, 7, 7), 32'h33, 0, {32'h33, 32'd9}, 2'b00, 0, 0);
    // fold of 3 beats; i_fold ignored once in ACC
    add_vec(1, 3'b110, 1, 3, bus4(1, 0, 0, 0), 32'h33, 0, {32'h33, 32'd9}, 2'b00, 1, 1);
    add_vec(1, 3'b110, 1, 0, bus4(2, 0, 0, 0), 32'h33, 0, {32'h33, 32'd9}, 2'b00, 1, 2);
    add_vec(1, 3'b110, 1, 0, bus4(3, 0, 0, 0), 32'h33, 0, {32'h33, 32'd6}, 2'b01, 0, 0);
    // interleaved add then flush
    add_vec(1, 3'b110, 1, 4, bus4(6, 0, 4, 0), 32'h33, 0, {32'h33, 32'd6}, 2'b00, 1, 1);
    add_vec(1, 3'b010, 1, 0, bus4(1, 0, 2, 0), 3, 1, {32'h33, 32'd6}, 2'b00, 1, 1);
    add_vec(1, 3'b111, 1, 0, bus4(2, 0, 3, 0), 3, 0, {32'h33, 32'd15}, 2'b01, 0, 0);
    // i_fold=0 behaves as 1; flush from IDLE emits S
    add_vec(1, 3'b110, 1, 0, bus4(5, 0, 3, 0), 3, 0, {32'h33, 32'd8}, 2'b01, 0, 0);
    add_vec(1, 3'b111, 1, 0, bus4(16, 0, 4, 0), 3, 0, {32'h33, 32'd20}, 2'b01, 0, 0);
    // overflow across beats, with an idle gap in ACC
    add_vec(1, 3'b110, 1, 2, bus4(32'h7FFF_FFFF, 0, 0, 0), 3, 0, {32'h33, 32'd20}, 2'b00, 1, 1);
    add_vec(0, 3'b111, 1, 0, bus4(9, 0, 9, 0), 3, 0, {32'h33, 32'd20}, 2'b00, 1, 1);
    add_vec(1, 3'b110, 1, 0, bus4(1, 0, 0, 0), 3, 0, {32'h33, OVF_EXP}, 2'b01, 0, 0);
    add_vec(1, 3'b010, 1, 0, bus4(32'hFFFF_FFFF, 0, 2, 0), 1, 1, {32'h33, OVF_EXP}, 2'b00, 0, 0);
    add_vec(1, 3'b010, 0, 0, bus4(100, 5, 200, 6), 11, 1, {32'h33, OVF_EXP}, 2'b00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].cmd, vecs[i].sel, vecs[i].fold, vecs[i].bus);
      @(negedge clk);
      chk_all(i, vecs[i].e_adder, vecs[i].e_av, vecs[i].e_vn, vecs[i].e_vv,
              vecs[i].e_busy, vecs[i].e_cnt);
    end

    // reset during ACC discards the partial sum
    drive(1, 3'b110, 1, 5, bus4(1, 0, 0, 0));
    @(negedge clk);
    chk_all(100, 11, 0, {32'h33, OVF_EXP}, 2'b00, 1, 1);
    rst = 1'b1;
    drive(0, 3'b000, 1, 0, '0);
    @(negedge clk);
    chk_all(101, 0, 0, 0, 2'b00, 0, 0);
    rst = 1'b0;
    drive(1, 3'b111, 1, 0, bus4(1, 0, 1, 0));
    @(negedge clk);
    chk_all(102, 0, 0, {32'h0, 32'd2}, 2'b01, 0, 0);
    drive(0, 3'b000, 1, 0, '0);
    @(negedge clk);
    chk_all(103, 0, 0, {32'h0, 32'd2}, 2'b00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
